wb_register_file: RTL and testbench
===================================

// Module: wb_register_file
// PURPOSE
// - Write-back consumer of the MEM/WB pipeline register: selects the write-back result and commits it to the 32-entry GPR file.
// - Serves the two decode-stage read ports (rs, rt); exports ResultW to the EX-stage forwarding muxes.
// - Sits between the MEM/WB register and the ID stage; one clock domain.
// PARAMETERS
// - DATA_W      32  register and result width in bits
// - ADDR_W      5   register index width; depth = 2**ADDR_W
// PORTS
// - CLK         in   1       system clock, rising-edge active
// - Reset       in   1       asynchronous, active-low reset
// - A1          in   ADDR_W  read port 1 index (rs)
// - A2          in   ADDR_W  read port 2 index (rt)
// - RD1         out  DATA_W  read port 1 data
// - RD2         out  DATA_W  read port 2 data
// - WriteRegW   in   ADDR_W  destination register from MEM/WB
// - ALUOutW     in   DATA_W  ALU result from MEM/WB
// - ReadDataW   in   DATA_W  load data from MEM/WB
// - RegWriteW   in   1       write enable from MEM/WB
// - MemtoRegW   in   1       1: write ReadDataW; 0: write ALUOutW
// - ResultW     out  DATA_W  selected write-back value, combinational
// BEHAVIOUR
// - ResultW = MemtoRegW ? ReadDataW : ALUOutW; purely combinational, no latency.
// - Write: on rising CLK with Reset high, if RegWriteW=1 and WriteRegW!=0, regs[WriteRegW] <= ResultW.
// - Register 0 is hardwired zero: writes to index 0 are dropped; RD1/RD2 read 0 for index 0 in every mode.
// - Reads are combinational from the array (zero-cycle latency), subject to the bypass rule under CONFIGURATION.
// - Reset low (asynchronous, any time, including mid-write): all 2**ADDR_W entries clear to 0 immediately; a write on the same edge as reset release is not committed.
// - While Reset is low: RD1=RD2=0 (array is zero); ResultW still follows its inputs, which the MEM/WB register drives to 0.
// - Simultaneous write and read of the same index: see CONFIGURATION; reads of different indices are unaffected by the write.
// - Both read ports may address the same register; each returns the identical value.
// - X/unknown index inputs are not defended against; the bench never drives them.
// CONFIGURATION
// - Macro: RF_WB_BYPASS_EN
// - Defined: write-first bypass. If RegWriteW=1, WriteRegW!=0 and An==WriteRegW, RDn = ResultW in the same cycle. The hazard unit then needs no extra stall for a WB->ID dependency.
// - Undefined: RDn always returns the stored array value, which is the pre-write value during the write cycle. The hazard unit must stall ID one extra cycle on a WB->ID match.
// - The index-0 rule overrides the bypass in both modes.
// STRUCTURE
// - Shared package mips_pkg: DATA_W, ADDR_W, REG_ZERO (5'd0) and the register-index typedef, reused by hazard and forwarding units.
// - One sub-module, wb_result_mux: a 2:1 DATA_W mux producing ResultW. The array, write logic and bypass stay in this module.
// TESTING
// - Reset: pulse Reset low mid-cycle after writing regs[5]=0xDEADBEEF -> RD1 at A1=5 reads 0 immediately; all 32 entries read 0.
// - Write ALU path: RegWriteW=1, MemtoRegW=0, WriteRegW=8, ALUOutW=0x00001234 -> ResultW=0x1234 combinationally; after the edge, A1=8 gives RD1=0x1234.
// - Write load path: MemtoRegW=1, ReadDataW=0xCAFEF00D, ALUOutW=0x1, WriteRegW=31 -> after the edge, A2=31 gives RD2=0xCAFEF00D.
// - Zero register: RegWriteW=1, WriteRegW=0, ALUOutW=0xFFFFFFFF -> A1=A2=0 give RD1=RD2=0 before and after the edge, in both macro modes.
// - Same-cycle hazard: regs[9]=0x11, write 0x22 to reg 9 with A1=9 -> RD1=0x22 before the edge with RF_WB_BYPASS_EN, 0x11 without; both modes read 0x22 after the edge.
// - Write gating: RegWriteW=0, WriteRegW=3, ALUOutW=0x55 -> regs[3] is unchanged after the edge; RD2 at A2=3 holds its previous value.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: datapath/index widths and the register-index type
// used by the register file, hazard unit and forwarding unit.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_result_mux.sv
// Write-back result select: load data when mem_to_reg_i is set, otherwise the ALU result.
module wb_result_mux #(
    parameter int DATA_W = 32
) (
    input  logic              mem_to_reg_i,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic [DATA_W-1:0] read_data_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = mem_to_reg_i ? read_data_i : alu_out_i;
    end

endmodule

// File: rtl/wb_register_file.sv
// WB-stage GPR file: commits ResultW, serves the two ID read ports, and exports ResultW.
// Optional macro RF_WB_BYPASS_EN enables write-first bypass onto the read ports.
module wb_register_file #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [DATA_W-1:0] ALUOutW,
    input  logic [DATA_W-1:0] ReadDataW,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    output logic [DATA_W-1:0] ResultW
);

    import mips_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_en;

    wb_result_mux #(
        .DATA_W (DATA_W)
    ) u_result_mux (
        .mem_to_reg_i (MemtoRegW),
        .alu_out_i    (ALUOutW),
        .read_data_i  (ReadDataW),
        .result_o     (ResultW)
    );

    always_comb begin
        wr_en = RegWriteW && (WriteRegW != IDX_ZERO);
    end

    // Entry 0 is cleared by reset and never written, so it reads zero from storage too.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[WriteRegW] <= ResultW;
        end
    end

    always_comb begin
        RD1 = regs_q[A1];
        RD2 = regs_q[A2];
`ifdef RF_WB_BYPASS_EN
        if (wr_en && (A1 == WriteRegW)) RD1 = ResultW;
        if (wr_en && (A2 == WriteRegW)) RD2 = ResultW;
`endif
        // Index 0 wins over any bypass.
        if (A1 == IDX_ZERO) RD1 = '0;
        if (A2 == IDX_ZERO) RD2 = '0;
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: per-cycle model comparison plus directed literals.
module tb_wb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          Reset;
    logic [AW-1:0] A1, A2, WriteRegW;
    logic [DW-1:0] RD1, RD2, ALUOutW, ReadDataW, ResultW;
    logic          RegWriteW, MemtoRegW;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mem [32];

    wb_register_file #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .WriteRegW (WriteRegW),
        .ALUOutW   (ALUOutW),
        .ReadDataW (ReadDataW),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .ResultW   (ResultW)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] exp_result();
        return MemtoRegW ? ReadDataW : ALUOutW;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && RegWriteW && WriteRegW != 0 && a == WriteRegW) return exp_result();
        return mem[a];
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference register array: cleared on reset assertion, updated at each committing edge.
    always @(negedge Reset) begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
    end

    always @(posedge CLK) begin
        if (Reset === 1'b1 && RegWriteW && WriteRegW != 0) mem[WriteRegW] = exp_result();
    end

    always @(negedge CLK) begin
        if (Reset !== 1'bx) begin
            check("model_ResultW", ResultW, exp_result());
            check("model_RD1", RD1, exp_read(A1));
            check("model_RD2", RD2, exp_read(A2));
        end
    end

    task automatic set_in(input logic we, input logic m2r, input logic [AW-1:0] wr,
                          input logic [DW-1:0] alu, input logic [DW-1:0] rdat,
                          input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        RegWriteW = we;
        MemtoRegW = m2r;
        WriteRegW = wr;
        ALUOutW   = alu;
        ReadDataW = rdat;
        A1        = a1;
        A2        = a2;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RegWriteW = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0;
        set_in(1'b0, 1'b0, '0, '0, '0, '0, '0);
        #1;
        check("reset_RD1", RD1, 32'h0);
        check("reset_RD2", RD2, 32'h0);
        #22 Reset = 1'b1;

        // Write regs[5], then async reset mid-cycle clears it immediately.
        step();
        set_in(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, '0, 5'd5, 5'd0);
        step();
        idle();
        check("pre_reset_r5", RD1, 32'hDEADBEEF);
        #3;
        Reset = 1'b0;
        set_in(1'b0, 1'b0, '0, '0, '0, 5'd5, 5'd0);
        #1;
        check("async_reset_r5", RD1, 32'h0);
        check("reset_ResultW", ResultW, 32'h0);
        for (int i = 0; i < 32; i++) begin
            A1 = AW'(i);
            A2 = AW'(31 - i);
            #1;
            check("reset_all_RD1", RD1, 32'h0);
            check("reset_all_RD2", RD2, 32'h0);
        end
        @(negedge CLK);
        #1 Reset = 1'b1;

        // ALU path
        step();
        set_in(1'b1, 1'b0, 5'd8, 32'h00001234, 32'hA5A5A5A5, 5'd8, 5'd0);
        #2;
        check("alu_ResultW", ResultW, 32'h00001234);
        step();
        idle();
        check("alu_RD1_after", RD1, 32'h00001234);

        // Load path
        set_in(1'b1, 1'b1, 5'd31, 32'h00000001, 32'hCAFEF00D, 5'd0, 5'd31);
        #2;
        check("load_ResultW", ResultW, 32'hCAFEF00D);
        step();
        idle();
        check("load_RD2_after", RD2, 32'hCAFEF00D);

        // Zero register
        set_in(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, '0, 5'd0, 5'd0);
        #2;
        check("zero_RD1_pre", RD1, 32'h0);
        check("zero_RD2_pre", RD2, 32'h0);
        step();
        idle();
        check("zero_RD1_post", RD1, 32'h0);
        check("zero_RD2_post", RD2, 32'h0);

        // Same-cycle hazard on reg 9; reg 8 on port 2 must be untouched.
        set_in(1'b1, 1'b0, 5'd9, 32'h00000011, '0, 5'd0, 5'd0);
        step();
        set_in(1'b1, 1'b0, 5'd9, 32'h00000022, '0, 5'd9, 5'd8);
        #2;
        check("hazard_RD1_pre", RD1, BYP ? 32'h00000022 : 32'h00000011);
        check("hazard_other_RD2", RD2, 32'h00001234);
        step();
        idle();
        check("hazard_RD1_post", RD1, 32'h00000022);

        // Both ports on the same register
        A1 = 5'd31;
        A2 = 5'd31;
        #1;
        check("same_idx_RD1", RD1, 32'hCAFEF00D);
        check("same_idx_RD2", RD2, 32'hCAFEF00D);

        // Write gating
        set_in(1'b1, 1'b0, 5'd3, 32'h00000033, '0, 5'd0, 5'd3);
        step();
        set_in(1'b0, 1'b0, 5'd3, 32'h00000055, '0, 5'd0, 5'd3);
        #2;
        check("gate_RD2_pre", RD2, 32'h00000033);
        step();
        check("gate_RD2_post", RD2, 32'h00000033);

        // Sweep: write a distinct pattern into every register, then read back via model checks.
        for (int i = 0; i < 32; i++) begin
            set_in(1'b1, i[0], AW'(i), 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
                   AW'(i), AW'((i + 1) % 32));
            step();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            A1 = AW'(i);
            A2 = AW'(31 - i);
            step();
        end
        A1 = 5'd2;
        A2 = 5'd3;
        #1;
        check("sweep_r2", RD1, 32'h1000_0002);
        check("sweep_r3", RD2, 32'h2000_0003);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
